// File: rtl/poseidon_input_packer.sv
// Packs IN_W-bit valid/ready beats, little-endian, into 256-bit Poseidon frames {last, payload[254:0]}.
// Optional build macro: POSEIDON_PACKER_RANGE_CHECK_EN adds a sticky bit-255 range error flag.
module poseidon_input_packer #(
  parameter int IN_W = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            io_input_valid,
  output logic            io_input_ready,
  input  logic            io_input_last,
  input  logic [IN_W-1:0] io_input_payload,
  output logic            io_output_valid,
  input  logic            io_output_ready,
  output logic            io_output_last,
  output logic [255:0]    io_output_payload,
  output logic            io_err_range
);

  localparam int WORDS = 256 / IN_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]       state_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [255:0]     acc_p0;
  logic [255:0]     merged;
  logic [255:0]     frame;
  logic [255:0]     frame_p1;
  logic             vld_p1;
  logic             accept;
  logic             final_beat;

  assign io_input_ready = !vld_p1 | io_output_ready;
  assign accept         = io_input_valid & io_input_ready;
  assign final_beat     = (cnt_p0 == CNT_W'(WORDS - 1)) | io_input_last;

  // Current beat merged into the accumulator; unwritten slots stay zero, so short elements pad.
  always_comb begin
    merged = (state_p0 == IDLE) ? '0 : acc_p0;
    for (int w = 0; w < WORDS; w++) begin
      if (cnt_p0 == CNT_W'(w)) merged[w*IN_W +: IN_W] = io_input_payload;
    end
    frame      = merged;
    frame[255] = io_input_last;
  end

  // Stage p0: beat collection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      acc_p0   <= '0;
    end else if (accept) begin
      if (final_beat) begin
        state_p0 <= IDLE;
        cnt_p0   <= '0;
        acc_p0   <= '0;
      end else begin
        state_p0 <= COLLECT;
        cnt_p0   <= cnt_p0 + CNT_W'(1);
        acc_p0   <= merged;
      end
    end
  end

  // Stage p1: frame output register; a new load wins over a same-cycle drain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1   <= 1'b0;
      frame_p1 <= '0;
    end else if (accept && final_beat) begin
      vld_p1   <= 1'b1;
      frame_p1 <= frame;
    end else if (io_output_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign io_output_valid   = vld_p1;
  assign io_output_payload = frame_p1;
  assign io_output_last    = frame_p1[255];

`ifdef POSEIDON_PACKER_RANGE_CHECK_EN
  logic err_range_p1;

  // Source bit 255 is lost to the last flag, so a set bit there is out of field range.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_range_p1 <= 1'b0;
    end else if (accept && final_beat && merged[255]) begin
      err_range_p1 <= 1'b1;
    end
  end

  assign io_err_range = err_range_p1;
`else
  assign io_err_range = 1'b0;
`endif

endmodule

// File: tb/tb_poseidon_input_packer.sv
// Scoreboard bench for poseidon_input_packer at IN_W=64 (4 beats per frame).
module tb_poseidon_input_packer;

  localparam int IN_W = 64;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_last = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic [255:0]    out_data;
  logic            err_range;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [255:0] exp_q[$];
  logic [255:0] m_acc = '0;
  int           m_cnt = 0;

  poseidon_input_packer #(.IN_W(IN_W)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .io_input_valid    (in_valid),
    .io_input_ready    (in_ready),
    .io_input_last     (in_last),
    .io_input_payload  (in_data),
    .io_output_valid   (out_valid),
    .io_output_ready   (out_ready),
    .io_output_last    (out_last),
    .io_output_payload (out_data),
    .io_err_range      (err_range)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitor: compare each handshaken frame with the scoreboard head
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      logic [255:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL frame_unexpected got=%h", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e || out_last !== e[255]) begin
          miscompares++;
          $display("FAIL frame got=%h last=%b want=%h", out_data, out_last, e);
        end
      end
    end
  end

  // Drives one beat until accepted; the reference packer pushes completed frames.
  task automatic send_beat(input logic [IN_W-1:0] d, input logic l);
    int   guard = 0;
    logic took = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!took && guard < 200) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!took) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_accept_timeout data=%h", d);
    end else begin
      m_acc[m_cnt*IN_W +: IN_W] = d;
      if (m_cnt == 3 || l) begin
        logic [255:0] f;
        f      = m_acc;
        f[255] = l;
        exp_q.push_back(f);
        m_acc  = '0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #3;
    vectors++;
    if ({out_valid, out_last, err_range, in_ready} !== 4'b0001 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b l=%b e=%b r=%b d=%h want 0,0,0,1,0",
               out_valid, out_last, err_range, in_ready, out_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_element();
    logic [255:0] want;
    want = {64'h8444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    send_beat(64'h1111_1111_1111_1111, 1'b0);
    send_beat(64'h2222_2222_2222_2222, 1'b0);
    send_beat(64'h3333_3333_3333_3333, 1'b0);
    send_beat(64'h0444_4444_4444_4444, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== want) begin
      miscompares++;
      $display("FAIL full_element got v=%b l=%b d=%h want v=1 l=1 d=%h", out_valid, out_last, out_data, want);
    end
    drain();
  endtask

  task automatic test_short_element();
    logic [255:0] want;
    want = {1'b1, 127'd0, 64'hB, 64'hA};
    send_beat(64'hA, 1'b0);
    send_beat(64'hB, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== want) begin
      miscompares++;
      $display("FAIL short_element got v=%b d=%h want v=1 d=%h", out_valid, out_data, want);
    end
    drain();
  endtask

  task automatic test_multi_frame();
    for (int i = 0; i < 8; i++) begin
      send_beat({1'b0, 31'($urandom), 32'($urandom)}, 1'b0);
      if (i == 3) begin
        vectors++;
        if (out_valid !== 1'b1 || out_last !== 1'b0) begin
          miscompares++;
          $display("FAIL multi_first_frame got v=%b l=%b want v=1 l=0", out_valid, out_last);
        end
      end
    end
    send_beat(64'h0000_0000_0000_0099, 1'b1);
    vectors++;
    if (out_data !== {1'b1, 191'd0, 64'h99}) begin
      miscompares++;
      $display("FAIL multi_third_frame got=%h want=%h", out_data, {1'b1, 191'd0, 64'h99});
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [255:0] held;
    int start;
    held = {64'h8000_0000_0000_00D4, 64'hD3, 64'hD2, 64'hD1};
    out_ready = 1'b0;
    send_beat(64'hD1, 1'b0);
    send_beat(64'hD2, 1'b0);
    send_beat(64'hD3, 1'b0);
    send_beat(64'hD4, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
        miscompares++;
        $display("FAIL backpressure_hold cyc=%0d got r=%b v=%b d=%h want r=0 v=1 d=%h",
                 i, in_ready, out_valid, out_data, held);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 4; i++) send_beat(64'hE0 + 64'(i), i == 3);
    vectors++;
    if (cyc - start != 4) begin
      miscompares++;
      $display("FAIL backpressure_release cycles=%0d want=4", cyc - start);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc;
    for (int i = 0; i < 8; i++) send_beat(64'h100 + 64'(i), (i % 4) == 3);
    vectors++;
    if (cyc - start != 8 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back cycles=%0d v=%b want 8 cycles v=1", cyc - start, out_valid);
    end
    drain();
  endtask

  task automatic test_range();
    logic want_err;
`ifdef POSEIDON_PACKER_RANGE_CHECK_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    send_beat(64'h5, 1'b0);
    send_beat(64'h6, 1'b0);
    send_beat(64'h7, 1'b0);
    send_beat(64'h8000_0000_0000_0001, 1'b1);
    vectors++;
    if (err_range !== want_err || out_data[255:192] !== 64'h8000_0000_0000_0001) begin
      miscompares++;
      $display("FAIL range_flag got e=%b top=%h want e=%b top=8000000000000001",
               err_range, out_data[255:192], want_err);
    end
    drain();
    send_beat(64'h1, 1'b1);
    vectors++;
    if (err_range !== want_err) begin
      miscompares++;
      $display("FAIL range_sticky got=%b want=%b", err_range, want_err);
    end
    drain();
  endtask

  task automatic test_reset_mid_element();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(64'h700 + 64'(i), i == 3);
    out_ready = 1'b1;
    send_beat(64'hAAAA, 1'b0);
    send_beat(64'hBBBB, 1'b0);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    #1;
    vectors++;
    if ({out_valid, out_last, err_range} !== 3'b000 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got v=%b l=%b e=%b d=%h want all 0", out_valid, out_last, err_range, out_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    send_beat(64'hC1, 1'b0);
    send_beat(64'hC2, 1'b1);
    vectors++;
    if (out_data !== {1'b1, 127'd0, 64'hC2, 64'hC1}) begin
      miscompares++;
      $display("FAIL reset_fresh got=%h want=%h", out_data, {1'b1, 127'd0, 64'hC2, 64'hC1});
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_full_element();
    test_short_element();
    test_multi_frame();
    test_backpressure();
    test_back_to_back();
    test_range();
    test_reset_mid_element();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
